// File: rtl/shift_unit_iter_pkg.sv
// Shared definitions for the iterative shift/rotate unit: op-codes, FSM states
// and a small op-decode helper.
package shift_unit_iter_pkg;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_ROL);
  endfunction

endpackage

// File: rtl/shift_unit_iter_step.sv
// Combinational single-chunk shifter/rotator: moves data by 0..STEP bits
// according to op. Unknown op-codes pass data through unchanged.
module shift_step
  import shift_unit_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int AW    = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] data_in,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] data_out
);

  localparam int SW = $clog2(WIDTH) + 1;

  logic [SW-1:0] amt_w;
  logic [SW-1:0] inv_w;

  // For amt=0 the complementary shift is by WIDTH, which yields zero,
  // so rotations degenerate cleanly to a pass-through.
  always_comb begin
    amt_w    = SW'(amt);
    inv_w    = SW'(WIDTH) - amt_w;
    data_out = data_in;
    case (op)
      OP_SHR:  data_out = data_in >> amt_w;
      OP_SHRA: data_out = $signed(data_in) >>> amt_w;
      OP_SHL:  data_out = data_in << amt_w;
      OP_ROR:  data_out = (data_in >> amt_w) | (data_in << inv_w);
      OP_ROL:  data_out = (data_in << amt_w) | (data_in >> inv_w);
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/shift_unit_iter.sv
// Multi-cycle shift/rotate unit: captures an operand on start and moves it by
// at most STEP bits per clock, pulsing done with the registered result.
module shift_unit_iter
  import shift_unit_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 4,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] Ra,
  input  logic [SHW-1:0]   shift_amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int AW = $clog2(STEP) + 1;
  localparam logic [SHW:0] STEP_W = (SHW + 1)'(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic [2:0]       op_q, op_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic             last_chunk;
  logic [AW-1:0]    chunk;
  logic [WIDTH-1:0] stepped;

  assign last_chunk = ({1'b0, rem_q} <= STEP_W);
  assign chunk      = last_chunk ? AW'(rem_q) : AW'(STEP);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AW    (AW)
  ) u_step (
    .data_in  (data_q),
    .op       (op_q),
    .amt      (chunk),
    .data_out (stepped)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    rem_d    = rem_q;
    op_d     = op_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          data_d  = Ra;
          op_d    = op;
          // Illegal ops run a single zero-length step so they pass Ra through.
          rem_d   = op_is_legal(op) ? shift_amt : '0;
          busy_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        data_d = stepped;
        if (last_chunk) begin
          state_d  = ST_IDLE;
          rem_d    = '0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = stepped;
        end else begin
          rem_d = rem_q - SHW'(STEP);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q  <= ST_IDLE;
      data_q   <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_shift_unit_iter.sv
// Directed bench for shift_unit_iter (WIDTH=32, STEP=4): latency, busy/done
// timing, operation results, back-to-back, ignored start and async clear.
module tb_shift_unit_iter;

  logic        clock;
  logic        clear_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] Ra;
  logic [4:0]  shift_amt;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  shift_unit_iter #(
    .WIDTH (32),
    .STEP  (4)
  ) dut (
    .clock     (clock),
    .clear_n   (clear_n),
    .start     (start),
    .op        (op),
    .Ra        (Ra),
    .shift_amt (shift_amt),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Starts at a negedge, ends at the negedge of the done cycle so that a
  // following call issues its start in the done cycle (back-to-back).
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [4:0] amt,
                        input logic [31:0] exp, input int n, input bit poke, input string name);
    start = 1'b1; op = o; Ra = a; shift_amt = amt;
    @(negedge clock);
    start = 1'b0; op = ~o; Ra = ~a; shift_amt = ~amt;
    for (int c = 1; c <= n; c++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s busy/done cycle %0d: got busy=%b done=%b, want busy=1 done=0",
                 name, c, busy, done);
      end
      start = (poke && c == 2) ? 1'b1 : 1'b0;
      @(negedge clock);
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done cycle: got busy=%b done=%b, want busy=0 done=1", name, busy, done);
    end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL %s result: got %h, want %h", name, result, exp);
    end
  endtask

  task automatic idle_gap(input logic [31:0] exp, input string name);
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || result !== exp) begin
      errors++;
      $display("FAIL %s idle: got busy=%b done=%b result=%h, want busy=0 done=0 result=%h",
               name, busy, done, result, exp);
    end
  endtask

  task automatic test_reset();
    clear_n = 1'b0; start = 1'b0; op = 3'b000; Ra = '0; shift_amt = '0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL reset: got busy=%b done=%b result=%h, want 0 0 00000000", busy, done, result);
    end
    clear_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_shra();
    run_op(3'b001, 32'hFFFF_FFF6, 5'd4, 32'hFFFF_FFFF, 1, 1'b0, "shra_neg4");
    idle_gap(32'hFFFF_FFFF, "shra_neg4");
    run_op(3'b001, 32'h7FFF_FFFF, 5'd4, 32'h07FF_FFFF, 1, 1'b0, "shra_pos4");
    idle_gap(32'h07FF_FFFF, "shra_pos4");
  endtask

  task automatic test_long();
    run_op(3'b001, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF, 8, 1'b0, "shra_31");
    run_op(3'b000, 32'h8000_0000, 5'd31, 32'h0000_0001, 8, 1'b0, "shr_31");
    idle_gap(32'h0000_0001, "shr_31");
  endtask

  task automatic test_rotate();
    run_op(3'b100, 32'h8000_0001, 5'd5,  32'h0000_0030, 2, 1'b0, "rol_5");
    run_op(3'b011, 32'h8000_0001, 5'd1,  32'hC000_0000, 1, 1'b0, "ror_1");
    run_op(3'b011, 32'h1234_5678, 5'd16, 32'h5678_1234, 4, 1'b0, "ror_16");
    run_op(3'b100, 32'h1234_5678, 5'd31, 32'h091A_2B3C, 8, 1'b0, "rol_31");
    idle_gap(32'h091A_2B3C, "rol_31");
  endtask

  task automatic test_zero_illegal();
    run_op(3'b010, 32'h0000_0001, 5'd0,  32'h0000_0001, 1, 1'b0, "shl_0");
    run_op(3'b111, 32'hDEAD_BEEF, 5'd9,  32'hDEAD_BEEF, 1, 1'b0, "illegal_111");
    run_op(3'b101, 32'h1234_5678, 5'd31, 32'h1234_5678, 1, 1'b0, "illegal_101");
    idle_gap(32'h1234_5678, "illegal_101");
  endtask

  task automatic test_back_to_back();
    run_op(3'b000, 32'h8000_0000, 5'd8,  32'h0080_0000, 2, 1'b0, "shr_8");
    run_op(3'b010, 32'h0000_0001, 5'd8,  32'h0000_0100, 2, 1'b0, "b2b_shl_8");
    run_op(3'b000, 32'h8000_0000, 5'd31, 32'h0000_0001, 8, 1'b1, "busy_start");
    idle_gap(32'h0000_0001, "busy_start");
    idle_gap(32'h0000_0001, "busy_start_2");
  endtask

  task automatic test_mid_reset();
    start = 1'b1; op = 3'b000; Ra = 32'hFFFF_FFFF; shift_amt = 5'd20;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    clear_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: got busy=%b done=%b result=%h, want 0 0 00000000",
               busy, done, result);
    end
    @(negedge clock);
    clear_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_after cycle %0d: got busy=%b done=%b, want 0 0", c, busy, done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_shra();
    test_long();
    test_rotate();
    test_zero_illegal();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
